mem_wb_skid_register: RTL and testbench

Parametrised successor to the MEM/WB pipeline register, sitting between the memory stage and the write-back stage of the ARM pipeline.
- Carries the same payload: wb_en, mem_r_en, ALU result, memory read value and destination.
- Adds a valid/ready handshake, a 2-entry skid buffer, and a flush that inserts a bubble.
- Lets write-back stall without a combinational ready path back into the memory stage.

---
 rtl/mem_wb_skid_register.sv | 150 +++++++++++++++
 tb/tb_mem_wb_skid_register.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_skid_register.sv
// mem_wb_skid_register: MEM/WB pipeline register with a valid/ready handshake,
// a 2-entry skid buffer and a bubble-inserting flush.
//
// Optional build macro: MEM_WB_STAT_CNT_EN
//   defined   -> stall_cnt / bubble_cnt are saturating statistics counters
//   undefined -> both counters are tied to 0 and no counter flops exist
//
// state | meaning
// ------+-------------------------------------------------------------
// EMPTY | nothing held, outputs invalid, ready for a new payload
// ONE   | main entry holds the payload on the outputs, skid empty
// FULL  | main entry on the outputs, skid holds the next payload,
//       | upstream is stalled (in_ready = 0)
//
// The state encoding is chosen so that bit 0 is main_v and bit 1 is skid_v.
// out_valid and in_ready therefore come straight from flops, and out_ready
// never reaches in_ready combinationally.

module mem_wb_skid_register #(
  parameter int DATA_W = 32,
  parameter int DEST_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,

  input  logic              in_valid,
  output logic              in_ready,
  input  logic              wb_en_in,
  input  logic              mem_r_en_in,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic [DATA_W-1:0] mem_read_value_in,
  input  logic [DEST_W-1:0] dest_in,

  output logic              out_valid,
  input  logic              out_ready,
  output logic              wb_en,
  output logic              mem_r_en,
  output logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] mem_read_value,
  output logic [DEST_W-1:0] dest,

  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  // Payload packing: {wb_en, mem_r_en, alu_result, mem_read_value, dest}
  localparam int PW = 2 + 2 * DATA_W + DEST_W;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } state_t;

  state_t          state;
  logic [PW-1:0]   main_q;
  logic [PW-1:0]   skid_q;
  logic [PW-1:0]   in_payload;
  logic            main_v;
  logic            skid_v;
  logic            in_fire;
  logic            out_fire;
  logic            main_wb_en;

  assign main_v = state[0];
  assign skid_v = state[1];

  assign in_payload = {wb_en_in, mem_r_en_in, alu_result_in, mem_read_value_in, dest_in};

  // rst gating keeps upstream from seeing a ready register while held in reset.
  assign in_ready  = rst & ~skid_v;
  assign out_valid = main_v;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // Handshake FSM: moves payloads between input, skid and main entries.
  // Flush only drops the valid bits; stale payload stays but wb_en is gated.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            main_q <= in_payload;
            state  <= ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_q <= in_payload;
          end else if (in_fire) begin
            skid_q <= in_payload;
            state  <= FULL;
          end else if (out_fire) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            main_q <= skid_q;
            state  <= ONE;
          end
        end
        default: begin
          state <= EMPTY;
        end
      endcase
    end
  end

  assign {main_wb_en, mem_r_en, alu_result, mem_read_value, dest} = main_q;

  // A flushed or empty register must never request a register-file write.
  assign wb_en = main_wb_en & main_v;

`ifdef MEM_WB_STAT_CNT_EN
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] bubble_q;

  // Saturating statistics: cleared only by reset, flush leaves them alone.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_q  <= '0;
      bubble_q <= '0;
    end else begin
      if (main_v && !out_ready && (stall_q != '1)) begin
        stall_q <= stall_q + CNT_W'(1);
      end
      if (!main_v && (bubble_q != '1)) begin
        bubble_q <= bubble_q + CNT_W'(1);
      end
    end
  end

  assign stall_cnt  = stall_q;
  assign bubble_cnt = bubble_q;
`else
  assign stall_cnt  = '0;
  assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_mem_wb_skid_register.sv
// Testbench for mem_wb_skid_register: directed scenarios followed by random
// traffic, checked against a queue-based reference model.
module tb_mem_wb_skid_register;

  localparam int DATA_W = 32;
  localparam int DEST_W = 4;
  localparam int CNT_W  = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic              wb_en;
    logic              mem_r_en;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] mrv;
    logic [DEST_W-1:0] dest;
  } pl_t;

  logic clk = 1'b0;
  logic rst, flush, in_valid, out_ready;
  pl_t  cur;

  logic              in_ready, out_valid, wb_en, mem_r_en;
  logic [DATA_W-1:0] alu_result, mem_read_value;
  logic [DEST_W-1:0] dest;
  logic [CNT_W-1:0]  stall_cnt, bubble_cnt;

  int total = 0;
  int bad   = 0;

  // reference model state
  pl_t exp_q[$];
  int  m_stall  = 0;
  int  m_bubble = 0;
  bit  rst_seen = 1'b1;

  always #5 clk = ~clk;

  mem_wb_skid_register #(.DATA_W(DATA_W), .DEST_W(DEST_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .wb_en_in(cur.wb_en), .mem_r_en_in(cur.mem_r_en),
    .alu_result_in(cur.alu), .mem_read_value_in(cur.mrv), .dest_in(cur.dest),
    .out_valid(out_valid), .out_ready(out_ready),
    .wb_en(wb_en), .mem_r_en(mem_r_en), .alu_result(alu_result),
    .mem_read_value(mem_read_value), .dest(dest),
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );

  function automatic pl_t mk(input logic w, input logic m, input logic [31:0] a,
                             input logic [31:0] v, input logic [3:0] d);
    pl_t p;
    p.wb_en = w; p.mem_r_en = m; p.alu = a; p.mrv = v; p.dest = d;
    return p;
  endfunction

  function automatic pl_t rnd_pl();
    return mk(1'($urandom), 1'($urandom), $urandom, $urandom, 4'($urandom));
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: a FIFO of accepted payloads holding at most two entries; the head
  // is what the write-back stage sees.
  always @(posedge clk) begin
    if (!rst) begin
      exp_q.delete();
      m_stall  = 0;
      m_bubble = 0;
      rst_seen = 1'b1;
    end else begin
      bit acc;
      rst_seen = 1'b0;
      if (exp_q.size() > 0 && !out_ready && m_stall < CNT_MAX) m_stall++;
      if (exp_q.size() == 0 && m_bubble < CNT_MAX) m_bubble++;
      acc = in_valid && (exp_q.size() < 2);
      if (flush) begin
        exp_q.delete();
      end else begin
        if (exp_q.size() > 0 && out_ready) void'(exp_q.pop_front());
        if (acc) exp_q.push_back(cur);
      end
    end
  end

  // Monitor: compares DUT outputs with the model shortly after each edge.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      chk("out_valid", 64'(out_valid), 64'(exp_q.size() > 0));
      chk("in_ready", 64'(in_ready), 64'(rst && exp_q.size() < 2));
      if (exp_q.size() > 0) begin
        chk("wb_en", 64'(wb_en), 64'(exp_q[0].wb_en));
        chk("mem_r_en", 64'(mem_r_en), 64'(exp_q[0].mem_r_en));
        chk("alu_result", 64'(alu_result), 64'(exp_q[0].alu));
        chk("mem_read_value", 64'(mem_read_value), 64'(exp_q[0].mrv));
        chk("dest", 64'(dest), 64'(exp_q[0].dest));
      end else begin
        chk("wb_en_gated", 64'(wb_en), 64'd0);
      end
      if (rst_seen) begin
        chk("rst_payload", {mem_r_en, alu_result, mem_read_value, dest}, 64'd0);
        chk("rst_dest", 64'(dest), 64'd0);
      end
`ifdef MEM_WB_STAT_CNT_EN
      chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
      chk("bubble_cnt", 64'(bubble_cnt), 64'(m_bubble));
`else
      chk("stall_cnt_tied", 64'(stall_cnt), 64'd0);
      chk("bubble_cnt_tied", 64'(bubble_cnt), 64'd0);
`endif
    end
  end

  task automatic step(input logic r, input logic fl, input logic iv, input pl_t p,
                      input logic ordy);
    rst = r; flush = fl; in_valid = iv; cur = p; out_ready = ordy;
    @(negedge clk);
  endtask

  initial begin
    pl_t a, b, c, z;
    z = mk(0, 0, 0, 0, 0);

    // reset held with in_valid high
    for (int i = 0; i < 3; i++) step(0, 0, 1, mk(1, 1, 32'h55, 32'h66, 4'h7), 1);
    step(1, 0, 0, z, 1);

    // streaming dest 1..8
    for (int i = 1; i <= 8; i++) step(1, 0, 1, mk(1, 0, 32'h100 + i, 32'h0, 4'(i)), 1);
    step(1, 0, 0, z, 1);
    step(1, 0, 0, z, 1);

    // backpressure A, B, C
    a = mk(1, 0, 32'hA, 32'h1, 4'd3);
    b = mk(1, 1, 32'hB, 32'h2, 4'd5);
    c = mk(0, 0, 32'hC, 32'h3, 4'd9);
    step(1, 0, 1, a, 0);
    step(1, 0, 1, b, 0);
    step(1, 0, 1, c, 0);
    step(1, 0, 1, c, 0);
    step(1, 0, 1, c, 1);
    step(1, 0, 1, c, 1);
    step(1, 0, 0, z, 1);
    step(1, 0, 0, z, 1);

    // flush in FULL with a same-cycle payload
    step(1, 0, 1, a, 0);
    step(1, 0, 1, b, 0);
    step(1, 1, 1, mk(1, 0, 32'hCC, 32'hCC, 4'd12), 0);
    step(1, 0, 0, z, 1);
    step(1, 0, 0, z, 1);

    // load passthrough
    step(1, 0, 1, mk(1, 1, 32'h0, 32'hDEADBEEF, 4'hF), 1);
    step(1, 0, 0, z, 1);

    // long stall saturates the stall counter, then flush, then reset
    step(1, 0, 1, a, 0);
    for (int i = 0; i < 20; i++) step(1, 0, 0, z, 0);
    step(1, 1, 0, z, 0);
    step(1, 0, 0, z, 1);
    step(0, 0, 0, z, 1);
    step(1, 0, 0, z, 1);

    // random traffic
    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(0, 99) != 0),
           ($urandom_range(0, 99) < 3),
           ($urandom_range(0, 99) < 70),
           rnd_pl(),
           ($urandom_range(0, 99) < 60));
    end
    step(1, 0, 0, z, 1);
    step(1, 0, 0, z, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
